// File: rtl/uart_tx_fifo_if.sv
// Byte-strobe interface between a *_ctrl producer and the buffered UART transmitter.
// The producer (master) drives byte and strobe; the transmitter (slave) reports FIFO and line status.
interface uart_tx_fifo_if;
    logic [7:0] pi_data;
    logic       pi_flag;
    logic       fifo_full;
    logic       busy;
    logic       ovf;

    modport master (
        output pi_data,
        output pi_flag,
        input  fifo_full,
        input  busy,
        input  ovf
    );

    modport slave (
        input  pi_data,
        input  pi_flag,
        output fifo_full,
        output busy,
        output ovf
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding an LSB-first 8N1 serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data (8E1).
module uart_tx_fifo #(
    parameter int UART_BPS   = 9600,
    parameter int CLK_FREQ   = 50_000_000,
    parameter int FIFO_DEPTH = 16
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    uart_tx_fifo_if.slave bus,
    output logic          tx
);

    localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam int BW           = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
    localparam int AW           = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t          state, state_nxt;
    logic [BW-1:0]   baud_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift;
    logic            baud_end;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count, count_nxt;
    logic            full, empty, push, pop;

    assign full     = (count == (AW+1)'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign baud_end = (baud_cnt == BW'(BAUD_CNT_MAX - 1));

    // A write may still land on a full FIFO when the transmitter pops in the same cycle.
    assign push = bus.pi_flag && (!full || pop);
    assign bus.fifo_full = full;

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // NOTE: the storage array has no reset; occupancy is tracked by count and pointers alone.
    always_ff @(posedge sys_clk) begin
        if (push) mem[wr_ptr] <= bus.pi_data;
    end

    // NOTE: state is updated with <= so every register samples pre-edge values.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            bus.ovf <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count   <= count_nxt;
            bus.ovf <= bus.pi_flag && full && !pop;
        end
    end

    // NOTE: defaults first so no path through the case leaves a signal unassigned.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = S_START;
                end
            end
            S_START: if (baud_end) state_nxt = S_DATA;
            S_DATA: begin
                if (baud_end && bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_nxt = S_PARITY;
`else
                    state_nxt = S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: if (baud_end) state_nxt = S_STOP;
`endif
            S_STOP: begin
                if (baud_end) begin
                    if (!empty) begin
                        pop       = 1'b1;
                        state_nxt = S_START;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            bus.busy <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE || state_nxt != state || baud_end)
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + 1'b1;
            if (state != S_DATA)
                bit_cnt <= '0;
            else if (baud_end)
                bit_cnt <= bit_cnt + 1'b1;
            if (pop)
                shift <= mem[rd_ptr];
            else if (state == S_DATA && baud_end)
                shift <= {1'b0, shift[7:1]};
            bus.busy <= (state_nxt != S_IDLE) || (count_nxt != '0);
        end
    end

`ifdef UART_TX_PARITY_EN
    logic parity_bit;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            parity_bit <= 1'b0;
        else if (pop)
            parity_bit <= ^mem[rd_ptr];
    end
`endif

    // tx follows the state one clock later, so the start bit appears two edges after the write.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tx <= 1'b1;
        end else begin
            case (state)
                S_START:  tx <= 1'b0;
                S_DATA:   tx <= shift[0];
`ifdef UART_TX_PARITY_EN
                S_PARITY: tx <= parity_bit;
`endif
                default:  tx <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected bytes, a line monitor decodes tx.
// Honours UART_TX_PARITY_EN (frame grows to 11 bits and the parity bit is checked).
module tb_uart_tx_fifo;

    localparam int CLK_FREQ = 160;
    localparam int UART_BPS = 10;
    localparam int DEPTH    = 4;
    localparam int B        = CLK_FREQ / UART_BPS;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic sys_clk = 1'b0;
    logic sys_rst_n;
    logic tx;

    uart_tx_fifo_if bus ();

    uart_tx_fifo #(
        .UART_BPS  (UART_BPS),
        .CLK_FREQ  (CLK_FREQ),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .bus      (bus),
        .tx       (tx)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ovf_cnt = 0;
    int ovf_exp = 0;
    int rst_epoch = 0;
    logic [7:0] exp_q[$];
    int start_q[$];

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected-response model: a burst issued into an idle, empty transmitter has its first
    // byte pulled straight into the shifter, so DEPTH+1 bytes are kept and the rest dropped.
    task automatic burst(input int n, input bit rnd, input logic [7:0] base);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            d = rnd ? 8'($urandom) : base + 8'(i);
            if (i <= DEPTH) exp_q.push_back(d);
            else            ovf_exp++;
            bus.pi_data = d;
            bus.pi_flag = 1'b1;
            @(negedge sys_clk);
        end
        bus.pi_flag = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < 5000) begin
            @(negedge sys_clk);
            n++;
        end
        check({name, "_idle_timeout"}, 32'(n < 5000), 32'd1);
        repeat (2 * B) @(negedge sys_clk);
    endtask

    initial begin : ovf_counter
        forever begin
            @(negedge sys_clk);
            if (bus.ovf === 1'b1) ovf_cnt++;
        end
    end

    initial begin : monitor
        forever begin
            @(negedge sys_clk);
            if (sys_rst_n === 1'b1 && tx === 1'b0) begin
                int ep;
                logic [7:0] b, e;
                logic sb, st, pb;
                ep = rst_epoch;
                pb = 1'b0;
                start_q.push_back(cyc);
                repeat (B / 2) @(negedge sys_clk);
                sb = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (B) @(negedge sys_clk);
                    b[i] = tx;
                end
`ifdef UART_TX_PARITY_EN
                repeat (B) @(negedge sys_clk);
                pb = tx;
`endif
                repeat (B) @(negedge sys_clk);
                st = tx;
                if (ep == rst_epoch) begin
                    check("start_bit", 32'(sb), 32'd0);
                    check("stop_bit", 32'(st), 32'd1);
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", 32'(b), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_data", 32'(b), 32'(e));
`ifdef UART_TX_PARITY_EN
                        check("parity_bit", 32'(pb), 32'(^e));
`endif
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int bad_tx, bad_busy, bad_ovf, ovf0, n;
        bus.pi_data = '0;
        bus.pi_flag = 1'b0;
        sys_rst_n   = 1'b0;

        // Reset held, then released with no traffic.
        repeat (5) @(negedge sys_clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        check("rst_full", 32'(bus.fifo_full), 32'd0);
        sys_rst_n = 1'b1;
        bad_tx = 0; bad_busy = 0; bad_ovf = 0;
        repeat (200) begin
            @(negedge sys_clk);
            if (tx !== 1'b1)       bad_tx++;
            if (bus.busy !== 1'b0) bad_busy++;
            if (bus.ovf !== 1'b0)  bad_ovf++;
        end
        check("idle_tx_cycles", 32'(bad_tx), 32'd0);
        check("idle_busy_cycles", 32'(bad_busy), 32'd0);
        check("idle_ovf_cycles", 32'(bad_ovf), 32'd0);

        // Single byte: latency, busy window.
        burst(1, 1'b0, 8'hA5);
        @(negedge sys_clk);
        check("lat_tx_n1", 32'(tx), 32'd1);
        check("lat_busy_n1", 32'(bus.busy), 32'd1);
        @(negedge sys_clk);
        check("lat_tx_n2", 32'(tx), 32'd0);
        repeat (FB * B - 2) @(negedge sys_clk);
        check("busy_last_frame_clk", 32'(bus.busy), 32'd1);
        @(negedge sys_clk);
        check("busy_after_frame", 32'(bus.busy), 32'd0);
        wait_idle("single");

        // Parity reference byte (also a plain frame in 8N1 builds).
        burst(1, 1'b0, 8'h07);
        wait_idle("b07");

        // Back-to-back burst: frames must abut exactly.
        start_q.delete();
        burst(3, 1'b0, 8'h01);
        wait_idle("burst3");
        check("burst3_frames", 32'(start_q.size()), 32'd3);
        if (start_q.size() == 3) begin
            check("burst3_gap01", 32'(start_q[1] - start_q[0]), 32'(FB * B));
            check("burst3_gap12", 32'(start_q[2] - start_q[1]), 32'(FB * B));
        end

        // Overflow: six writes, one dropped.
        ovf0 = ovf_cnt;
        ovf_exp = 0;
        burst(6, 1'b0, 8'h10);
        check("ovf_full", 32'(bus.fifo_full), 32'd1);
        wait_idle("ovf");
        check("ovf_pulses", 32'(ovf_cnt - ovf0), 32'(ovf_exp));

        // Write while full on the edge where STOP ends and pops.
        ovf0 = ovf_cnt;
        burst(5, 1'b0, 8'h20);
        check("pp_full_before", 32'(bus.fifo_full), 32'd1);
        repeat (FB * B - 4) @(negedge sys_clk);
        bus.pi_data = 8'h30;
        bus.pi_flag = 1'b1;
        exp_q.push_back(8'h30);
        @(negedge sys_clk);
        bus.pi_flag = 1'b0;
        check("pp_ovf", 32'(bus.ovf), 32'd0);
        check("pp_full_after", 32'(bus.fifo_full), 32'd1);
        wait_idle("pushpop");
        check("pp_ovf_pulses", 32'(ovf_cnt - ovf0), 32'd0);

        // Randomised bursts from idle.
        for (int k = 0; k < 12; k++) begin
            repeat ($urandom_range(0, 5)) @(negedge sys_clk);
            ovf0 = ovf_cnt;
            ovf_exp = 0;
            n = $urandom_range(1, 7);
            burst(n, 1'b1, 8'h00);
            wait_idle("rand");
            check("rand_ovf_pulses", 32'(ovf_cnt - ovf0), 32'(ovf_exp));
        end

        // Reset asserted during data bit 3 of 8'h07 with a second byte queued.
        burst(2, 1'b0, 8'h07);
        repeat (4 * B + B / 2 - 1) @(negedge sys_clk);
        check("mid_bit3_tx", 32'(tx), 32'd0);
        #1;
        sys_rst_n = 1'b0;
        rst_epoch++;
        exp_q.delete();
        #1;
        check("abort_tx", 32'(tx), 32'd1);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_full", 32'(bus.fifo_full), 32'd0);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        bad_tx = 0; bad_busy = 0;
        repeat (12 * B) begin
            @(negedge sys_clk);
            if (tx !== 1'b1)       bad_tx++;
            if (bus.busy !== 1'b0) bad_busy++;
        end
        check("post_abort_tx", 32'(bad_tx), 32'd0);
        check("post_abort_busy", 32'(bad_busy), 32'd0);

        // Transmitter still usable after the abort.
        burst(1, 1'b0, 8'h3C);
        wait_idle("post_abort");
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
